// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for the execute stage.
// Holds the pipeline through stallreq_o until {rem, quo} is ready.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BYZERO = 2'b01;
  localparam logic [1:0] ON     = 2'b10;
  localparam logic [1:0] END    = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] a_abs, b_abs;
  logic [32:0] diff;
  logic [64:0] step;
  logic [31:0] quo, rem;

  always_comb begin
    a_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    b_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    diff  = {1'b0, work_q[63:32]} - {1'b0, dvsr_q};
    // Borrow means the trial subtraction failed: shift in a 0 quotient bit
    step  = diff[32] ? {work_q[63:0], 1'b0}
                     : {diff[31:0], work_q[31:0], 1'b1};
    quo   = negq_q ? (~step[31:0] + 32'd1) : step[31:0];
    rem   = negr_q ? (~step[64:33] + 32'd1) : step[64:33];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = 64'd0;
    ready_d  = 1'b0;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          negq_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          negr_d  = signed_div_i & opdata1_i[31];
          dvsr_d  = b_abs;
          work_d  = {32'd0, a_abs, 1'b0};
          cnt_d   = 5'd0;
          state_d = (opdata2_i == 32'd0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
          cnt_d   = 5'd0;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {rem, quo};
          end
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_d = FREE;
        end else begin
          ready_d  = 1'b1;
          result_d = result_q;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= 5'd0;
      work_q   <= 65'd0;
      dvsr_q   <= 32'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, annul, reset.
// Inputs change 1 time unit after each rising edge.
module tb_div_unit;

  localparam logic [1:0] FREE = 2'b00;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int total;
  int passed;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready),
    .stallreq_o  (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat,
                         input bit hold);
    int n;
    bit stall_gap;
    n = 0;
    stall_gap = 1'b0;
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    #1;
    check({tag, "_stall_t0"}, 64'(stallreq), 64'd1);
    while (!ready && n < 60) begin
      tick();
      n++;
      op1 = 32'hDEAD_BEEF;
      op2 = 32'h0000_0003;
      #1;
      if (!ready && !stallreq) stall_gap = 1'b1;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_stall_hi"}, 64'(stall_gap), 64'd0);
    check({tag, "_result"}, result, exp);
    check({tag, "_stall_rdy"}, 64'(stallreq), 64'd0);
    if (hold) begin
      tick();
      check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
      check({tag, "_hold_res"}, result, exp);
    end
    start = 1'b0;
    tick();
    check({tag, "_free"}, 64'(dut.state_q), 64'(FREE));
    check({tag, "_rdy_clr"}, 64'(ready), 64'd0);
    check({tag, "_res_clr"}, result, 64'd0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    tick();
    tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(FREE));
    check("rst_stall", 64'(stallreq), 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
            64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
            64'h00000001_FFFFFFFD, 33, 1'b0);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
            64'h00000000_80000000, 33, 1'b0);
    run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
            64'h00000000_FFFFFFFF, 33, 1'b0);
    run_div("u5_9", 1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 33, 1'b0);
    run_div("u_by0", 1'b0, 32'd1234, 32'd0, 64'd0, 2, 1'b0);
    run_div("s_by0", 1'b1, 32'hFFFFFF00, 32'd0, 64'd0, 2, 1'b0);

    // annul together with start in FREE: nothing starts
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    annul = 1'b1;
    tick();
    check("annul_free_state", 64'(dut.state_q), 64'(FREE));
    start = 1'b0;
    annul = 1'b0;
    tick();

    // annul mid-divide in cycle T+10
    start = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) tick();
    check("annul_pre_rdy", 64'(ready), 64'd0);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check("annul_state", 64'(dut.state_q), 64'(FREE));
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    run_div("post_annul", 1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 33, 1'b0);

    // reset in cycle T+20 of a divide, start held through it
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state", 64'(dut.state_q), 64'(FREE));
    check("mrst_ready", 64'(ready), 64'd0);
    check("mrst_result", result, 64'd0);
    check("mrst_stall", 64'(stallreq), 64'd1);
    run_div("post_rst", 1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 33, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the execute stage: one quotient bit per cycle (radix-2 restoring), signed or unsigned. It is the requesting side of the pipeline stall protocol. While a divide is in flight it drives `stallreq_o`, which the execute stage forwards as its stall request to the stall controller, freezing PC through EX. It returns `{remainder, quotient}` for the HI/LO write.

## Interface
- No parameters; data width fixed at 32, result width 64.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high (`RstEnable` = 1).
- `signed_div_i` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i` in FREE.
- `opdata1_i` in 32: dividend; sampled at start.
- `opdata2_i` in 32: divisor; sampled at start.
- `start_i` in 1: EX requests a divide; held high by EX until it sees `ready_o`.
- `annul_i` in 1: cancel (flush/exception); aborts any in-flight divide.
- `result_o` out 64: `{remainder[31:0], quotient[31:0]}`; valid only while `ready_o`=1, else 0.
- `ready_o` out 1: result valid (registered).
- `stallreq_o` out 1: stall request = `start_i & ~ready_o` (combinational).

## Operation
- States: FREE, BYZERO, ON, END. All outputs and state are registered except `stallreq_o`.
- Reset (`rst`=1 at an edge): state FREE, `result_o`=0, `ready_o`=0, iteration counter=0. Reset overrides every state, including mid-divide.
- FREE, with `start_i`=1 and `annul_i`=0:
  - divisor==0 → BYZERO.
  - Otherwise → ON with cnt=0.
  - Signed mode: latch |dividend| and |divisor| (two's complement negate if bit31 set). Remember both sign bits.
  - Unsigned mode: latch operands as given.
  - 65-bit work register = `{32'b0, dividend_abs, 1'b0}`.
- FREE, otherwise: stay in FREE; outputs stay 0.
- BYZERO → END with `result_o`=0 (quotient 0, remainder 0). No exception is raised.
- ON, `annul_i`=1: → FREE; `result_o`=0, `ready_o`=0, cnt=0.
- ON, `annul_i`=0: one restoring step per cycle.
  - diff = work[63:32] − divisor (33-bit).
  - Borrow: work ← work<<1.
  - No borrow: work ← `{diff[31:0], work[31:0], 1'b1}`.
  - cnt++.
  - On the step where cnt==31, compute the final result in the same edge and go → END.
- Final values:
  - quotient = work[31:0]; remainder = work[64:33] after the 32nd step.
  - Signed only: negate quotient if the dividend and divisor signs differ. Negate remainder if the dividend was negative.
  - Arithmetic is modulo 2^32, so 0x80000000 / −1 = 0x80000000, remainder 0.
- END:
  - `ready_o`=1; `result_o` holds the final value.
  - If `start_i`=0: → FREE; `ready_o`=0, `result_o`=0.
  - If `start_i` stays 1, hold END.
  - `annul_i` in END also → FREE with outputs cleared.
- Operand changes after start are ignored until the next FREE→start.

## Timing
- Start sampled at the edge ending cycle T.
- ON occupies cycles T+1 … T+32.
- END (`ready_o`=1) from cycle T+33: 33-cycle latency from start to ready.
- Divide by zero: BYZERO in cycle T+1, `ready_o`=1 in cycle T+2.
- `stallreq_o`:
  - High from cycle T (same cycle `start_i` rises) until `ready_o` rises.
  - Low in the `ready_o` cycle, so EX advances and drops `start_i`.
  - The next edge returns the unit to FREE, so a result is consumed exactly once.
- Back-to-back divides: `start_i` must drop for at least one cycle (the END→FREE edge). A new start is accepted in the following FREE cycle.
- `annul_i` and `start_i` high together in FREE: annul wins, no divide starts.
- Annul takes effect at the next edge; outputs are 0 from the following cycle.

## Test plan
- Unsigned 100 / 7, start held: `ready_o` rises exactly 33 cycles after start; `result_o`=64'h00000002_0000000E. `stallreq_o` is 1 for cycles T..T+32 and 0 at T+33. State is FREE one cycle after `start_i` drops.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): `result_o`=64'hFFFFFFFF_FFFFFFFD. Signed 7 / −2: 64'h00000001_FFFFFFFD.
- Edge operands:
  - Signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 → 64'h00000000_FFFFFFFF.
  - Unsigned 5 / 9 → 64'h00000005_00000000.
- Divide by zero (either mode): `ready_o`=1 at T+2 with `result_o`=0. Divider returns to FREE after `start_i` drops.
- Annul in cycle T+10 of an ON sequence: state FREE at T+11; `ready_o` never rises; `result_o`=0. An immediate new start (100/7) then completes correctly in 33 cycles.
- `rst` asserted mid-divide (cycle T+20): all outputs 0 and state FREE after that edge. A held `start_i` after reset deasserts restarts a fresh 33-cycle divide.
